// File: rtl/button_event_gen.sv
`default_nettype none
// =============================================================================
// Module   : button_event_gen
// Summary  : Turns five debounced button levels into queued press events (and,
//            with BUTTON_EVT_REPEAT_EN defined, hold-to-repeat events) that are
//            presented one at a time on a valid/ready port.
// Revision : 1.0 - initial release
// =============================================================================
module button_event_gen #(
  parameter int unsigned HOLD_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       up,
  input  logic       center,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_rpt,
  output logic       evt_drop,
  output logic [4:0] held
);

  localparam int C_NBTN = 5;

  // Empty on legal settings; the condition keeps the ranges visible at elaboration.
  if ((HOLD_DELAY < 2) || (REPEAT_PERIOD < 1) || (CNT_W < 1)) begin : g_param_range_bad
  end

  logic [4:0] w_level;
  logic [4:0] w_press;
  logic [4:0] w_rpt_ev;
  logic [4:0] w_evt;
  logic [4:0] w_clr;
  logic       w_load;
  logic       w_any_pend;
  logic [2:0] w_win_idx;
  logic       w_win_kind;

  logic [4:0] prev_q;
  logic [4:0] pend_q, pend_d;
  logic       evt_valid_q, evt_valid_d;
  logic [2:0] evt_code_q, evt_code_d;
  logic       evt_rpt_q, evt_rpt_d;
  logic       evt_drop_q, evt_drop_d;

  assign w_level    = {center, up, left, down, right};
  assign w_press    = w_level & ~prev_q;
  assign w_evt      = w_press | w_rpt_ev;
  assign w_load     = ~evt_valid_q | evt_ready;
  assign w_any_pend = |pend_q;

  // Lowest pending index wins; scanning downward lets the last hit stand.
  always_comb begin
    w_win_idx = 3'd0;
    for (int i = C_NBTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        w_win_idx = 3'(i);
      end
    end
  end

  assign w_clr = (w_load && w_any_pend) ? (5'b00001 << w_win_idx) : 5'b00000;

  // A slot that is being emptied this cycle may be refilled; otherwise the
  // older event is kept and the newer one is discarded.
  always_comb begin
    pend_d     = pend_q;
    evt_drop_d = 1'b0;
    for (int i = 0; i < C_NBTN; i++) begin
      if (w_evt[i]) begin
        if (pend_q[i] && !w_clr[i]) begin
          evt_drop_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
        end
      end else if (w_clr[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_rpt_d   = evt_rpt_q;
    if (w_load) begin
      evt_valid_d = w_any_pend;
      if (w_any_pend) begin
        evt_code_d = w_win_idx;
        evt_rpt_d  = w_win_kind;
      end
    end
  end

`ifdef BUTTON_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] C_RPT_LOAD  = CNT_W'(REPEAT_PERIOD - 1);

  logic [4:0] kind_q, kind_d;

  for (genvar g = 0; g < C_NBTN; g++) begin : g_hold
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rpt_fire;

    // Counts down while held; a zero count on a held cycle fires a repeat.
    always_comb begin
      cnt_d    = cnt_q;
      rpt_fire = 1'b0;
      if (!w_level[g]) begin
        cnt_d = '0;
      end else if (!prev_q[g]) begin
        cnt_d = C_HOLD_LOAD;
      end else if (cnt_q == '0) begin
        rpt_fire = 1'b1;
        cnt_d    = C_RPT_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign w_rpt_ev[g] = rpt_fire;
  end

  always_comb begin
    kind_d = kind_q;
    for (int i = 0; i < C_NBTN; i++) begin
      if (w_evt[i] && !(pend_q[i] && !w_clr[i])) begin
        kind_d[i] = w_rpt_ev[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q <= '0;
    end else begin
      kind_q <= kind_d;
    end
  end

  assign w_win_kind = kind_q[w_win_idx];
`else
  assign w_rpt_ev   = 5'b00000;
  assign w_win_kind = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 3'd0;
      evt_rpt_q   <= 1'b0;
      evt_drop_q  <= 1'b0;
    end else begin
      prev_q      <= w_level;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_rpt_q   <= evt_rpt_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_rpt   = evt_rpt_q;
  assign evt_drop  = evt_drop_q;
  assign held      = prev_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// =============================================================================
// Module   : tb_button_event_gen
// Summary  : Scoreboard bench for button_event_gen; directed presses push
//            expected events, a monitor pops them on every accepted transfer.
// Revision : 1.0 - initial release
// =============================================================================
module tb_button_event_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       right = 1'b0, down = 1'b0, left = 1'b0, up = 1'b0, center = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_rpt;
  logic       evt_drop;
  logic [4:0] held;

  always #5 clk = ~clk;

  button_event_gen #(
    .HOLD_DELAY   (8),
    .REPEAT_PERIOD(4),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .right    (right),
    .down     (down),
    .left     (left),
    .up       (up),
    .center   (center),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_rpt  (evt_rpt),
    .evt_drop (evt_drop),
    .held     (held)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] code;
    logic       rpt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   fails   = 0;
  int   drops   = 0;

  logic       stall_prev = 1'b0;
  logic [2:0] stall_code = 3'd0;
  logic       stall_rpt  = 1'b0;
  exp_t       e;

  // Monitor: samples on the falling edge, i.e. what the next rising edge sees.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (evt_drop === 1'b1) drops++;
      if (stall_prev) begin
        vectors++;
        if (evt_valid !== 1'b1 || evt_code !== stall_code || evt_rpt !== stall_rpt) begin
          fails++;
          $display("FAIL stall_stable @%0d: valid=%b code=%0d rpt=%b, required valid=1 code=%0d rpt=%b",
                   cyc, evt_valid, evt_code, evt_rpt, stall_code, stall_rpt);
        end
      end
      stall_prev = (evt_valid === 1'b1) && (evt_ready === 1'b0);
      stall_code = evt_code;
      stall_rpt  = evt_rpt;
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event @%0d: code=%0d rpt=%b, required no event", cyc, evt_code, evt_rpt);
        end else begin
          e = exp_q.pop_front();
          if (evt_code !== e.code || evt_rpt !== e.rpt || (e.cyc >= 0 && e.cyc != cyc)) begin
            fails++;
            $display("FAIL event @%0d: code=%0d rpt=%b, required code=%0d rpt=%b at cycle %0d",
                     cyc, evt_code, evt_rpt, e.code, e.rpt, e.cyc);
          end
        end
      end
    end
  end

  function automatic void push(input logic [2:0] code, input logic rpt, input int at);
    exp_t x;
    x.code = code;
    x.rpt  = rpt;
    x.cyc  = at;
    exp_q.push_back(x);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @%0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL %s_drain @%0d: %0d events outstanding, required 0", name, cyc, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_idle"}, {31'd0, evt_valid}, 32'd0);
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d0;

    // Reset with center held; first post-reset edge counts as a press.
    center = 1'b1;
    tick(3);
    chk("reset_state", {24'd0, evt_valid, evt_code, evt_rpt, evt_drop, held}, 32'd0);
    evt_ready = 1'b1;
    rst       = 1'b0;
    c = cyc;
    push(3'd4, 1'b0, c + 2);
    tick(3);
    chk("held_center", {27'd0, held}, 32'h10);
    tick(2);
    center = 1'b0;
    drain("reset_press", 20);

    // Single press: valid one edge after the press edge, then idle.
    c = cyc;
    right = 1'b1;
    push(3'd0, 1'b0, c + 2);
    tick(2);
    right = 1'b0;
    drain("single", 20);

    // Simultaneous presses emit in index order, back to back.
    d0 = drops;
    c  = cyc;
    right = 1'b1; left = 1'b1; up = 1'b1;
    push(3'd0, 1'b0, c + 2);
    push(3'd2, 1'b0, c + 3);
    push(3'd3, 1'b0, c + 4);
    tick(2);
    right = 1'b0; left = 1'b0; up = 1'b0;
    drain("simul", 20);
    chk("simul_no_drop", drops - d0, 32'd0);

    // Backpressure: output holds first press, slot holds second, third drops.
    d0 = drops;
    evt_ready = 1'b0;
    down = 1'b1; tick(1);
    down = 1'b0; tick(1);
    down = 1'b1; tick(1);
    down = 1'b0; tick(1);
    down = 1'b1; tick(1);
    down = 1'b0;
    push(3'd1, 1'b0, -1);
    push(3'd1, 1'b0, -1);
    tick(3);
    chk("bp_valid_held", {28'd0, evt_valid, evt_code}, 32'h9);
    evt_ready = 1'b1;
    drain("backpressure", 20);
    chk("bp_one_drop", drops - d0, 32'd1);

    // Long hold of up for 20 sampled edges.
    c = cyc;
    up = 1'b1;
    push(3'd3, 1'b0, c + 2);
`ifdef BUTTON_EVT_REPEAT_EN
    push(3'd3, 1'b1, c + 10);
    push(3'd3, 1'b1, c + 14);
    push(3'd3, 1'b1, c + 18);
`endif
    tick(20);
    up = 1'b0;
    tick(12);
    drain("hold", 20);

    // Reset while an event is stalled and another is pending: both lost.
    evt_ready = 1'b0;
    right = 1'b1; left = 1'b1;
    tick(3);
    chk("pre_rst_valid", {28'd0, evt_valid, evt_code}, 32'h8);
    rst = 1'b1;
    right = 1'b0; left = 1'b0;
    tick(1);
    chk("rst_mid_clear", {26'd0, evt_valid, evt_drop, held}, 32'd0);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    chk("post_rst_idle", {31'd0, evt_valid}, 32'd0);
    chk("post_rst_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Sits directly downstream of the five-button debounce stage; consumes its debounced levels (right, down, left, up, center).
- Converts each press into one queued event, plus optional hold-to-repeat events.
- Presents events one at a time on a valid/ready interface with a 3-bit button code, for the program-counter/shifter control logic.
- Prevents a held button from advancing the PC every clock.

Parameters:
- HOLD_DELAY, 50000000: cycles a button must be held after its press before the first repeat event; legal range ≥2.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat events while still held; legal range ≥1.
- CNT_W, 26: width of each per-button hold counter; must satisfy 2^CNT_W > max(HOLD_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock; same clock as the debounce stage.
- rst  input  1  synchronous, active-high reset.
- right  input  1  debounced level, button index 0.
- down  input  1  debounced level, button index 1.
- left  input  1  debounced level, button index 2.
- up  input  1  debounced level, button index 3.
- center  input  1  debounced level, button index 4.
- evt_valid  output  1  event available on evt_code/evt_rpt.
- evt_ready  input  1  consumer accepts event when high with evt_valid.
- evt_code  output  3  button index 0..4; codes 5..7 never produced.
- evt_rpt  output  1  0 = press event, 1 = auto-repeat event.
- evt_drop  output  1  one-cycle pulse: an event was discarded because its button's pending slot was occupied.
- held  output  5  registered copy of the input levels, bit i = button i.

Behaviour:
- Clocking and reset: single clock domain; the inputs are already debounced and synchronous, so no extra synchroniser.
- Reset values: while rst is high at a clk edge, evt_valid=0, evt_code=0, evt_rpt=0, evt_drop=0, held=0, all pending bits=0, all counters=0, prev levels=0.
- Reset mid-handshake: an un-accepted event is lost. A button held through reset produces one press event after reset is released, because prev resets to 0.
- Edge detect: prev[i] is registered from level[i] every cycle. A press occurs when level[i]=1 and prev[i]=0 at the same edge.
- Pending slots: one per button, holding {pend, kind}. A press sets pend=1, kind=0. A repeat sets pend=1, kind=1.
- Drop rule: if pend is already 1 and not being loaded this cycle, the new event is discarded and evt_drop pulses for 1 cycle. The newer event never overwrites an older one.
- Output register: loads when evt_valid=0, or when evt_valid&evt_ready=1 (transfer) this cycle.
- Arbitration: on load, the lowest-index pending button wins. The register takes evt_code=index, evt_rpt=kind, evt_valid=1, and that button's pend clears. If nothing is pending on a transfer, evt_valid goes to 0.
- Back-to-back: a transfer and a new load can happen in the same cycle, giving one event per cycle throughput.
- Latency: press sampled at edge k sets pend at edge k. evt_valid rises at edge k+1 if the output register is free.
- Stability: while evt_valid=1 and evt_ready=0, evt_code and evt_rpt are held stable.
- Same-cycle set and load: if a button's slot is loaded into the output while a new event for the same button arrives, the new event sets pend. Nothing is dropped.
- Hold counter (per button, counts down):
  - On press, load HOLD_DELAY-1.
  - While level=1 and prev=1, decrement.
  - At 0, issue a repeat event and reload REPEAT_PERIOD-1.
  - On release (level=0), force the counter to 0 and issue no event.
- Repeat timing: repeats land HOLD_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles after that.
- Release events: none.
- Simultaneous presses: all pend bits set in the same cycle, and the events are emitted in index order.

Optional Feature:
- Macro: BUTTON_EVT_REPEAT_EN.
- Defined: the hold counters and repeat events are present as described; evt_rpt can be 1.
- Undefined: no counters are instantiated; only press events are generated; evt_rpt is tied to 0; HOLD_DELAY, REPEAT_PERIOD and CNT_W are ignored.

Test Plan:
- Reset with center held, then release rst, evt_ready=1: one event code=4, rpt=0, valid one cycle after the first post-reset edge; no further events while held (repeat disabled or HOLD_DELAY not reached).
- Single press: right 0→1 at edge k, evt_ready=1 → evt_valid at k+1, code=0, rpt=0, valid low at k+2.
- Simultaneous press of right, left and up, evt_ready=1: codes 0, 2, 3 on three consecutive cycles, evt_drop=0.
- Backpressure: evt_ready=0, press down, release, press down again → second press sets pend while the first waits; a third press → evt_drop pulse. After ready=1: exactly two code=1 events, then valid=0.
- With BUTTON_EVT_REPEAT_EN, HOLD_DELAY=8, REPEAT_PERIOD=4: hold up from edge k for 20 cycles, ready=1 → press at k+1; repeats (code=3, rpt=1) valid at k+9, k+13, k+17; none after release.
- rst asserted while evt_valid=1 and evt_ready=0 → next edge: evt_valid=0 and pending cleared; no stale event after rst drops, with buttons low.
